hazard_scoreboard: RTL and testbench

Parametrised stall/forward controller for the pipelined MIPS core, replacing fixed per-stage comparisons with a shift-register scoreboard.
- Tracks destination register and remaining result latency (T_new) for STAGES post-decode stages.
- Against the D-stage instruction's T_use, it resolves the D-level forward source and asserts stall.
- Adds a multi-cycle mult/div busy counter, which the single-cycle predecessor lacks.

---
 rtl/hazard_scoreboard_pkg.sv | 49 ++++
 rtl/hazard_scoreboard_md_busy_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-resolution constants for the MIPS pipeline.
// T_INF marks an operand that is never read (or a result that never needs
// forwarding); FWD_RF is the "take the register file" forward code. The
// per-class timing table is what the decoder uses to drive d_t_use_* / d_t_new.
package hazard_scoreboard_pkg;

   localparam int TW = 3;
   localparam logic [TW-1:0] T_INF = 3'b111;
   localparam int FWD_RF = 0;

   typedef enum logic [3:0] {
      CLS_NOP    = 4'd0,
      CLS_CAL_R  = 4'd1,
      CLS_CAL_I  = 4'd2,
      CLS_LOAD   = 4'd3,
      CLS_STORE  = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_JUMP_R = 4'd6,
      CLS_JUMP_I = 4'd7,
      CLS_CMOV   = 4'd8,
      CLS_MD     = 4'd9
   } instr_class_e;

   typedef struct packed {
      logic [TW-1:0] t_use_rs;
      logic [TW-1:0] t_use_rt;
      logic [TW-1:0] t_new;
   } timing_t;

   // Operand need-times (cycles after D) and result ready-times (cycles after
   // entering E) for each instruction class.
   function automatic timing_t class_timing(input instr_class_e cls);
      timing_t t;
      case (cls)
         CLS_CAL_R:  t = '{3'd1,  3'd1,  3'd1};
         CLS_CAL_I:  t = '{3'd1,  T_INF, 3'd1};
         CLS_LOAD:   t = '{3'd1,  T_INF, 3'd2};
         CLS_STORE:  t = '{3'd1,  3'd2,  3'd0};
         CLS_BRANCH: t = '{3'd0,  3'd0,  3'd0};
         CLS_JUMP_R: t = '{3'd0,  T_INF, 3'd0};
         CLS_JUMP_I: t = '{T_INF, T_INF, 3'd0};
         CLS_CMOV:   t = '{3'd1,  3'd1,  3'd1};
         CLS_MD:     t = '{3'd1,  3'd1,  3'd1};
         default:    t = '{T_INF, T_INF, 3'd0};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multi-cycle mult/div occupancy counter. A start loads the operation's
// latency (a new load takes priority over the final decrement), otherwise the
// count runs down to zero; busy is high while the count is nonzero.
module md_busy_counter #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic div,
   output logic busy
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // Load on start, else count down to zero and hold there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end else begin
         count <= count;
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller built on a shift-register scoreboard of
// {destination register, remaining latency} for each post-decode stage
// (entry 0 = E ... entry STAGES-1 = W). stall and fwd_* respond in the same
// cycle to the D-stage inputs.
// Optional macro HAZARD_PERF_EN: when defined, stall_cycles counts clock edges
// with stall high; when undefined it is tied to zero.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int  STAGES      = 3,
   parameter int  REG_W       = 5,
   parameter int  T_W         = 3,
   parameter int  MULT_CYCLES = 5,
   parameter int  DIV_CYCLES  = 10,
   localparam int FWD_W       = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic [T_W-1:0]   d_t_use_rs,
   input  logic [T_W-1:0]   d_t_use_rt,
   input  logic [REG_W-1:0] d_regw,
   input  logic [T_W-1:0]   d_t_new,
   input  logic             d_md_start,
   input  logic             d_md_div,
   input  logic             d_md_use,
   output logic             stall,
   output logic [FWD_W-1:0] fwd_rs,
   output logic [FWD_W-1:0] fwd_rt,
   output logic             md_busy,
   output logic [31:0]      stall_cycles
);

   logic [REG_W-1:0] sb_regw [STAGES];
   logic [T_W-1:0]   sb_tnew [STAGES];

   logic             rs_hit, rt_hit, m_rs, m_rt;
   logic [FWD_W-1:0] rs_sel, rt_sel;
   logic [T_W-1:0]   rs_tnew, rt_tnew;
   logic             data_stall, md_stall;

   function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] v);
      return (v == '0) ? '0 : v - T_W'(1);
   endfunction

   // Youngest-match search: walk oldest to youngest so the lowest k wins.
   always_comb begin
      rs_hit  = 1'b0;
      rt_hit  = 1'b0;
      rs_sel  = '0;
      rt_sel  = '0;
      rs_tnew = '0;
      rt_tnew = '0;
      m_rs    = 1'b0;
      m_rt    = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         m_rs    = (d_rs != '0) && (sb_regw[k] == d_rs);
         m_rt    = (d_rt != '0) && (sb_regw[k] == d_rt);
         rs_hit  = m_rs ? 1'b1 : rs_hit;
         rs_sel  = m_rs ? FWD_W'(k + 1) : rs_sel;
         rs_tnew = m_rs ? sb_tnew[k] : rs_tnew;
         rt_hit  = m_rt ? 1'b1 : rt_hit;
         rt_sel  = m_rt ? FWD_W'(k + 1) : rt_sel;
         rt_tnew = m_rt ? sb_tnew[k] : rt_tnew;
      end
   end

   // Stall and forward decisions from the youngest match and the HI/LO unit.
   always_comb begin
      data_stall = (rs_hit && (rs_tnew > d_t_use_rs)) ||
                   (rt_hit && (rt_tnew > d_t_use_rt));
      md_stall   = d_md_use && md_busy;
      stall      = data_stall || md_stall;
      fwd_rs     = (rs_hit && (rs_tnew == '0)) ? rs_sel : FWD_W'(FWD_RF);
      fwd_rt     = (rt_hit && (rt_tnew == '0)) ? rt_sel : FWD_W'(FWD_RF);
   end

   // Scoreboard advance: entries always shift; only entry 0 sees a bubble on stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            sb_regw[k] <= '0;
            sb_tnew[k] <= '0;
         end
      end else begin
         sb_regw[0] <= stall ? '0 : d_regw;
         sb_tnew[0] <= stall ? '0 : d_t_new;
         for (int k = 1; k < STAGES; k++) begin
            sb_regw[k] <= sb_regw[k-1];
            sb_tnew[k] <= sat_dec(sb_tnew[k-1]);
         end
      end
   end

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_counter (
      .clk   (clk),
      .reset (reset),
      .load  (d_md_start && !stall),
      .div   (d_md_div),
      .busy  (md_busy)
   );

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_count;

   // Count every clock edge on which D is held; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_count <= 32'd0;
      end else if (stall) begin
         perf_count <= perf_count + 32'd1;
      end else begin
         perf_count <= perf_count;
      end
   end

   assign stall_cycles = perf_count;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The reference model keeps the
// last STAGES issued instructions with their original ready time and derives
// the remaining latency from their age.
module tb_hazard_scoreboard;

   localparam int STAGES = 3;
   localparam int MULTC  = 5;
   localparam int DIVC   = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, d_regw;
   logic [2:0]  d_t_use_rs, d_t_use_rt, d_t_new;
   logic        d_md_start, d_md_div, d_md_use;
   logic        stall, md_busy;
   logic [1:0]  fwd_rs, fwd_rt;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .STAGES(STAGES), .REG_W(5), .T_W(3), .MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)
   ) dut (
      .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
      .d_t_use_rs(d_t_use_rs), .d_t_use_rt(d_t_use_rt), .d_regw(d_regw),
      .d_t_new(d_t_new), .d_md_start(d_md_start), .d_md_div(d_md_div),
      .d_md_use(d_md_use), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
      .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   int          hist_reg [STAGES];
   int          hist_tn  [STAGES];
   int          md_left;
   int          perf_model;
   logic        exp_stall, exp_busy;
   logic [1:0]  exp_fwd_rs, exp_fwd_rt;
   logic [31:0] exp_perf;

   task automatic model_reset();
      for (int i = 0; i < STAGES; i++) begin
         hist_reg[i] = 0;
         hist_tn[i]  = 0;
      end
      md_left    = 0;
      perf_model = 0;
   endtask

   task automatic model_eval();
      int rem;
      bit rs_done, rt_done;
      exp_stall  = 1'b0;
      exp_fwd_rs = 2'd0;
      exp_fwd_rt = 2'd0;
      rs_done    = 0;
      rt_done    = 0;
      for (int k = 0; k < STAGES; k++) begin
         rem = (hist_tn[k] > k) ? hist_tn[k] - k : 0;
         if (!rs_done && d_rs != 5'd0 && hist_reg[k] == int'(d_rs)) begin
            rs_done = 1;
            if (rem == 0) exp_fwd_rs = 2'(k + 1);
            if (rem > int'(d_t_use_rs)) exp_stall = 1'b1;
         end
         if (!rt_done && d_rt != 5'd0 && hist_reg[k] == int'(d_rt)) begin
            rt_done = 1;
            if (rem == 0) exp_fwd_rt = 2'(k + 1);
            if (rem > int'(d_t_use_rt)) exp_stall = 1'b1;
         end
      end
      exp_busy = (md_left > 0);
      if (d_md_use && md_left > 0) exp_stall = 1'b1;
`ifdef HAZARD_PERF_EN
      exp_perf = 32'(perf_model);
`else
      exp_perf = 32'd0;
`endif
   endtask

   task automatic model_update();
      if (exp_stall) perf_model++;
      for (int k = STAGES - 1; k >= 1; k--) begin
         hist_reg[k] = hist_reg[k-1];
         hist_tn[k]  = hist_tn[k-1];
      end
      hist_reg[0] = exp_stall ? 0 : int'(d_regw);
      hist_tn[0]  = exp_stall ? 0 : int'(d_t_new);
      if (d_md_start && !exp_stall) md_left = d_md_div ? DIVC : MULTC;
      else if (md_left > 0) md_left--;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      model_eval();
   endtask

   task automatic set_d(input int rs, input int rt, input int tur, input int tut,
                        input int rw, input int tn, input int ms, input int md, input int mu);
      d_rs = 5'(rs); d_rt = 5'(rt); d_t_use_rs = 3'(tur); d_t_use_rt = 3'(tut);
      d_regw = 5'(rw); d_t_new = 3'(tn);
      d_md_start = 1'(ms); d_md_div = 1'(md); d_md_use = 1'(mu);
      model_eval();
   endtask

   task automatic flush();
      set_d(0, 0, 7, 7, 0, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_rs, fwd_rt); end
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf got=%0d exp=0", stall_cycles); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      model_eval();
   endtask

   task automatic test_load_use();
      flush();
      set_d(29, 0, 1, 7, 8, 2, 0, 0, 0);            // lw $8
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall got=%b exp=0", stall); end
      tick();
      set_d(8, 8, 1, 1, 9, 1, 0, 0, 0);             // addu $9,$8,$8
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got=%b exp=1", stall); end
      tick();
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
      checks++; if (fwd_rs !== exp_fwd_rs || fwd_rt !== exp_fwd_rt) begin errors++; $display("FAIL lu_fwd got=%0d/%0d exp=%0d/%0d", fwd_rs, fwd_rt, exp_fwd_rs, exp_fwd_rt); end
      tick();
      set_d(8, 0, 1, 7, 10, 1, 0, 0, 0);            // load value now in W
      @(negedge clk);
      checks++; if (fwd_rs !== 2'd3 || stall !== 1'b0) begin errors++; $display("FAIL lu_fwd_w got fwd=%0d stall=%b exp fwd=3 stall=0", fwd_rs, stall); end
      tick();
   endtask

   task automatic test_ori_forward();
      flush();
      set_d(0, 0, 7, 7, 8, 1, 0, 0, 0);             // ori $8
      tick();
      set_d(8, 0, 1, 7, 9, 1, 0, 0, 0);             // addu $9,$8,$0
      @(negedge clk);
      checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin errors++; $display("FAIL ori_e got stall=%b fwd=%0d exp stall=0 fwd=0", stall, fwd_rs); end
      tick();
      set_d(8, 0, 0, 7, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (stall !== 1'b0 || fwd_rs !== 2'd2) begin errors++; $display("FAIL ori_m got stall=%b fwd=%0d exp stall=0 fwd=2", stall, fwd_rs); end
      tick();
   endtask

   task automatic test_youngest();
      flush();
      set_d(0, 0, 7, 7, 8, 0, 0, 0, 0);
      tick();
      set_d(0, 0, 7, 7, 8, 0, 0, 0, 0);
      tick();
      set_d(8, 0, 0, 7, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (fwd_rs !== 2'd1) begin errors++; $display("FAIL youngest_e got=%0d exp=1", fwd_rs); end
      tick();
      @(negedge clk);
      checks++; if (fwd_rs !== 2'd2) begin errors++; $display("FAIL youngest_m got=%0d exp=2", fwd_rs); end
      tick();
   endtask

   task automatic test_reg_zero();
      flush();
      set_d(0, 0, 7, 7, 0, 2, 0, 0, 0);             // writes $0, t_new 2
      tick();
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", stall); end
      checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL r0_fwd got=%0d/%0d exp=0/0", fwd_rs, fwd_rt); end
      tick();
   endtask

   task automatic run_md(input int is_div, input int want, input string tag);
      int n;
      flush();
      set_d(4, 5, 1, 1, 0, 0, 1, is_div, 1);        // mult/div
      @(negedge clk);
      checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL %s_issue got stall=%b busy=%b exp 0/0", tag, stall, md_busy); end
      tick();
      set_d(0, 0, 7, 7, 2, 1, 0, 0, 1);             // mflo/mfhi
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 40) begin
         checks++; if (md_busy !== 1'b1 || exp_stall !== 1'b1) begin errors++; $display("FAIL %s_busy cyc=%0d got busy=%b stall=1 exp busy=1 stall=%b", tag, n, md_busy, exp_stall); end
         tick();
         @(negedge clk);
         n++;
      end
      checks++; if (n != want) begin errors++; $display("FAIL %s_len got=%0d exp=%0d", tag, n, want); end
      checks++; if (md_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL %s_release got busy=%b stall=%b exp 0/0", tag, md_busy, stall); end
      tick();
   endtask

   task automatic test_md_div();
      run_md(1, DIVC, "div");
   endtask

   task automatic test_md_mult();
      run_md(0, MULTC, "mult");
   endtask

   task automatic test_perf();
      logic [31:0] target;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      model_eval();
      for (int i = 0; i < 3; i++) begin
         set_d(29, 0, 1, 7, 8, 2, 0, 0, 0);
         tick();
         set_d(8, 8, 1, 1, 9, 1, 0, 0, 0);
         tick();
         tick();
         flush();
      end
      run_md(1, DIVC, "perf_div");
      flush();
`ifdef HAZARD_PERF_EN
      target = 32'd13;
`else
      target = 32'd0;
`endif
      @(negedge clk);
      checks++; if (stall_cycles !== target) begin errors++; $display("FAIL perf_total got=%0d exp=%0d", stall_cycles, target); end
   endtask

   task automatic test_async_reset();
      flush();
      set_d(0, 0, 7, 7, 0, 0, 1, 1, 1);             // div
      tick();
      set_d(29, 0, 1, 7, 8, 2, 0, 0, 0);            // lw $8
      tick();
      set_d(8, 8, 1, 1, 9, 1, 0, 0, 0);             // addu $9,$8,$8
      @(negedge clk);
      checks++; if (stall !== 1'b1 || md_busy !== 1'b1) begin errors++; $display("FAIL ar_pre got stall=%b busy=%b exp 1/1", stall, md_busy); end
      #1 reset = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall got=%b exp=0", stall); end
      checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL ar_fwd got=%0d/%0d exp=0/0", fwd_rs, fwd_rt); end
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", md_busy); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL ar_perf got=%0d exp=0", stall_cycles); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      set_d(0, 0, 7, 7, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3) == 0));
         @(negedge clk);
         checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_stall); end
         checks++; if (fwd_rs !== exp_fwd_rs) begin errors++; $display("FAIL rnd_fwd_rs c=%0d got=%0d exp=%0d", c, fwd_rs, exp_fwd_rs); end
         checks++; if (fwd_rt !== exp_fwd_rt) begin errors++; $display("FAIL rnd_fwd_rt c=%0d got=%0d exp=%0d", c, fwd_rt, exp_fwd_rt); end
         checks++; if (md_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, md_busy, exp_busy); end
         checks++; if (stall_cycles !== exp_perf) begin errors++; $display("FAIL rnd_perf c=%0d got=%0d exp=%0d", c, stall_cycles, exp_perf); end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      model_reset();
      set_d(0, 0, 7, 7, 0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_ori_forward();
      test_youngest();
      test_reg_zero();
      test_md_div();
      test_md_mult();
      test_perf();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
